id_ex_pipe_reg: RTL and testbench

Parametrised successor to the fixed-field decode/execute stage register. It carries a generic control vector and data vector between two pipeline stages under a valid/ready handshake, so upstream stalls without losing instructions. Flushed slots become bubbles with all control bits cleared, and a saturating stall counter supports performance monitoring. It sits between ID and EXE, and can be reused for EXE/MEM and MEM/WB.

---
 rtl/id_ex_pipe_reg.sv | 132 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode/execute stage register carrying generic ctrl/data vectors under valid/ready.
// ID_EX_SKID_EN defined: main+skid storage with registered in_ready; undefined: single entry.
module id_ex_pipe_reg #(
  parameter int unsigned CTRL_W              = 9,
  parameter int unsigned DATA_W              = 92,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W               = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              acc, fire;

`ifdef ID_EX_SKID_EN
  logic              in_ready_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  assign in_ready = in_ready_q;
`else
  // Single entry: accept only when the head leaves this cycle or is empty.
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign acc  = in_valid && in_ready;
  assign fire = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
`ifdef ID_EX_SKID_EN
      in_ready_q  <= 1'b1;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
`endif
    end else if (flush) begin
      // Killed slots become bubbles; a concurrent input is dropped.
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
`ifdef ID_EX_SKID_EN
      in_ready_q  <= 1'b1;
      skid_ctrl_q <= '0;
      if (CLEAR_DATA_ON_FLUSH) skid_data_q <= '0;
`endif
      if (CLEAR_DATA_ON_FLUSH) main_data_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (acc && fire) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
`ifdef ID_EX_SKID_EN
          end else if (acc) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
`endif
          end else if (fire) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
`ifdef ID_EX_SKID_EN
        FULL: begin
          if (fire) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            in_ready_q  <= 1'b1;
            state_q     <= BUSY;
          end
        end
`endif
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall counter: clear wins over increment, saturates at all-ones, ignores flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)
      stall_cnt_d = '0;
    else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized + directed bench for id_ex_pipe_reg against a queue-based stage model.
module tb_id_ex_pipe_reg;
  localparam int CW = 9;
  localparam int DW = 92;
  localparam int NW = 4;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, stall_clr = 1'b0;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic [DW-1:0] in_data = '0, out_data;
  logic [NW-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b1), .CNT_W(NW)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
  ent_t          q[$];     // entries held by the stage, head first
  logic [DW-1:0] m_data;   // value out_data should show (head, or last head if drained)
  int            m_cnt;
  int            total = 0, bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic m_reset();
    q.delete();
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic check_outs();
    bit v;
    v = q.size() != 0;
    chk("out_valid", 128'(out_valid), 128'(v));
    chk("out_ctrl",  128'(out_ctrl),  v ? 128'(q[0].c) : 128'(0));
    chk("out_data",  128'(out_data),  128'(m_data));
    chk("in_ready",  128'(in_ready),  128'(m_ready()));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
  endtask

  // Drive one cycle of inputs at the negedge, check, then advance the model across the edge.
  task automatic step(input logic f, input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic clr);
    bit acc, fire, v;
    ent_t e;
    flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; stall_clr = clr;
    #1 check_outs();
    v    = q.size() != 0;
    acc  = iv && m_ready();
    fire = v && ordy;
    if (clr) m_cnt = 0;
    else if (v && !ordy && m_cnt < (1 << NW) - 1) m_cnt++;
    if (f) begin
      q.delete();
      m_data = '0;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        e.c = c; e.d = d;
        q.push_back(e);
      end
      if (q.size() != 0) m_data = q[0].d;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    m_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1 check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 9'h1FF, DW'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: A1, A2 pushed with downstream stalled, A3 held upstream.
    step(1'b0, 1'b1, 9'h0A1, DW'('hA1), 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'h0A2, DW'('hA2), 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'h0A3, DW'('hA3), 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'h0A3, DW'('hA3), 1'b0, 1'b0);
    chk("bp_head", 128'(out_data), 128'('hA1));
    for (int i = 0; i < 4 && q.size() < 3; i++) begin
      if (q.size() != 0 && q[q.size()-1].d == DW'('hA3)) idle(1'b1);
      else step(1'b0, 1'b1, 9'h0A3, DW'('hA3), 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush while holding entries, with a simultaneous input that must be dropped.
    step(1'b0, 1'b1, 9'h011, DW'('h11), 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'h012, DW'('h12), 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h0B0, DW'('hB0), 1'b0, 1'b0);
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_data",  128'(out_data),  128'(0));
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Stall counter saturation and clear.
    step(1'b0, 1'b1, 9'h055, DW'('h55), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("stall_sat", 128'(stall_cnt), 128'(15));
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("stall_clr", 128'(stall_cnt), 128'(0));
    idle(1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Asynchronous reset asserted mid-cycle while holding entries.
    step(1'b0, 1'b1, 9'h077, DW'('h77), 1'b0, 1'b0);
    step(1'b0, 1'b1, 9'h078, DW'('h78), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom};
      step(($urandom % 20) == 0, ($urandom % 4) != 0, CW'($urandom), d,
           ($urandom % 3) != 0, ($urandom % 25) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
